// File: rtl/display_scan_ctrl_if.sv
// Value-source handshake for display_scan_ctrl: binary value in, load strobe,
// conversion status back to the source.
interface display_scan_ctrl_if;
  logic [7:0] num;
  logic       load;
  logic       busy;
  logic       done;

  modport master (
    output num,
    output load,
    input  busy,
    input  done
  );

  modport slave (
    input  num,
    input  load,
    output busy,
    output done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment controller: multi-cycle binary-to-BCD conversion
// (shift-add-3) followed by time-multiplexed digit scanning.
module display_scan_ctrl #(
  parameter int unsigned DIV = 50000,
  parameter bit          LZB = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  display_scan_ctrl_if.slave  bus,
  output logic [0:6]          sseg,
  output logic [3:0]          an,
  output logic                led
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [0:6] SegBlank = 7'b1111111;
  localparam logic [0:6] SegDash  = 7'b1111110;

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e        state_q;
  logic [7:0]    shreg_q;
  logic [11:0]   bcd_q;
  logic [11:0]   disp_q;
  logic [2:0]    bitcnt_q;
  logic          busy_q;
  logic          done_q;
  logic          led_q;

  logic [11:0]   bcd_adj;
  logic [11:0]   bcd_next;

  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic          tick;

  logic [3:0]    an_d;
  logic [0:6]    sseg_d;

  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One shift-add-3 step: correct every nibble, then shift in the next binary bit.
  always_comb begin
    bcd_adj  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_next = {bcd_adj[10:0], shreg_q[7]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      shreg_q  <= 8'd0;
      bcd_q    <= 12'd0;
      disp_q   <= 12'd0;
      bitcnt_q <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.load) begin
            state_q  <= StConv;
            shreg_q  <= bus.num;
            bcd_q    <= 12'd0;
            bitcnt_q <= 3'd0;
            busy_q   <= 1'b1;
          end
        end
        StConv: begin
          bcd_q    <= bcd_next;
          shreg_q  <= {shreg_q[6:0], 1'b0};
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_q <= StIdle;
            disp_q  <= bcd_next;
            led_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (tick) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Leading-zero blanking never touches the units digit.
  always_comb begin
    logic blank_u;
    logic blank_t;
    logic blank_h;
    blank_u = !led_q;
    blank_h = !led_q || (LZB && (disp_q[11:8] == 4'd0));
    blank_t = !led_q || (LZB && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0));
    an_d    = 4'b1111;
    sseg_d  = SegBlank;
    case (idx_q)
      2'd0: begin
        an_d   = 4'b1110;
        sseg_d = blank_u ? SegBlank : seg7(disp_q[3:0]);
      end
      2'd1: begin
        an_d   = 4'b1101;
        sseg_d = blank_t ? SegBlank : seg7(disp_q[7:4]);
      end
      2'd2: begin
        an_d   = 4'b1011;
        sseg_d = blank_h ? SegBlank : seg7(disp_q[11:8]);
      end
      default: begin
        an_d   = 4'b0111;
        sseg_d = busy_q ? SegDash : SegBlank;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      an   <= 4'b1111;
      sseg <= SegBlank;
    end else begin
      an   <= an_d;
      sseg <= sseg_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign led      = led_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: two instances (LZB=1 and LZB=0) share
// all inputs, DIV=4.
module tb_display_scan_ctrl;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] S7  = 7'b0001111;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0000100;
  localparam logic [6:0] SBL = 7'b1111111;
  localparam logic [6:0] SDH = 7'b1111110;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] num;
  logic [0:6] sseg_a, sseg_b;
  logic [3:0] an_a, an_b;
  logic       led_a, led_b;
  int         vecs = 0;
  int         errs = 0;
  int         cnt;

  always #5 clk = ~clk;

  display_scan_ctrl_if bus_a ();
  display_scan_ctrl_if bus_b ();

  assign bus_a.num  = num;
  assign bus_a.load = load;
  assign bus_b.num  = num;
  assign bus_b.load = load;

  display_scan_ctrl #(.DIV(4), .LZB(1'b1)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_a),
    .sseg (sseg_a),
    .an   (an_a),
    .led  (led_a)
  );

  display_scan_ctrl #(.DIV(4), .LZB(1'b0)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_b),
    .sseg (sseg_b),
    .an   (an_b),
    .led  (led_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] want, input string tag);
    for (int i = 0; i < 40; i++) begin
      step();
      if (an_a == want) break;
    end
    chk(tag, {4'd0, an_a}, {4'd0, want});
  endtask

  task automatic convert(input logic [7:0] n);
    num  = n;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (9) step();
  endtask

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    num  = 8'd0;

    // Reset state
    repeat (3) step();
    chk("rst_an",   {4'd0, an_a}, 8'b0000_1111);
    chk("rst_sseg", {1'b0, sseg_a}, {1'b0, SBL});
    chk("rst_busy", {7'd0, bus_a.busy}, 8'd0);
    chk("rst_done", {7'd0, bus_a.done}, 8'd0);
    chk("rst_led",  {7'd0, led_a}, 8'd0);

    // Scan after release, all blank
    rst = 1'b1;
    step();
    chk("scan0_an",   {4'd0, an_a}, 8'b0000_1110);
    chk("scan0_sseg", {1'b0, sseg_a}, {1'b0, SBL});
    repeat (4) step();
    chk("scan1_an",   {4'd0, an_a}, 8'b0000_1101);
    chk("scan1_sseg", {1'b0, sseg_a}, {1'b0, SBL});
    repeat (4) step();
    chk("scan2_an",   {4'd0, an_a}, 8'b0000_1011);
    chk("scan2_sseg", {1'b0, sseg_a}, {1'b0, SBL});
    repeat (4) step();
    chk("scan3_an",   {4'd0, an_a}, 8'b0000_0111);
    chk("scan3_sseg", {1'b0, sseg_a}, {1'b0, SBL});
    repeat (4) step();
    chk("scan4_an",   {4'd0, an_a}, 8'b0000_1110);

    // Full value 255: latency and done pulse
    num  = 8'd255;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("f_busy_e0", {7'd0, bus_a.busy}, 8'd1);
    repeat (7) step();
    chk("f_busy_e7", {7'd0, bus_a.busy}, 8'd1);
    chk("f_done_e7", {7'd0, bus_a.done}, 8'd0);
    chk("f_led_e7",  {7'd0, led_a}, 8'd0);
    step();
    chk("f_busy_e8", {7'd0, bus_a.busy}, 8'd0);
    chk("f_done_e8", {7'd0, bus_a.done}, 8'd1);
    chk("f_led_e8",  {7'd0, led_a}, 8'd1);
    step();
    chk("f_done_e9", {7'd0, bus_a.done}, 8'd0);
    wait_an(4'b1110, "f_u_an");
    chk("f_units", {1'b0, sseg_a}, {1'b0, S5});
    wait_an(4'b1101, "f_t_an");
    chk("f_tens", {1'b0, sseg_a}, {1'b0, S5});
    wait_an(4'b1011, "f_h_an");
    chk("f_hund", {1'b0, sseg_a}, {1'b0, S2});
    wait_an(4'b0111, "f_d3_an");
    chk("f_d3", {1'b0, sseg_a}, {1'b0, SBL});

    // Leading-zero blanking, num=7
    convert(8'd7);
    wait_an(4'b1110, "z7_u_an");
    chk("z7_units_a", {1'b0, sseg_a}, {1'b0, S7});
    chk("z7_units_b", {1'b0, sseg_b}, {1'b0, S7});
    wait_an(4'b1101, "z7_t_an");
    chk("z7_tens_a", {1'b0, sseg_a}, {1'b0, SBL});
    chk("z7_tens_b", {1'b0, sseg_b}, {1'b0, S0});
    wait_an(4'b1011, "z7_h_an");
    chk("z7_hund_a", {1'b0, sseg_a}, {1'b0, SBL});
    chk("z7_hund_b", {1'b0, sseg_b}, {1'b0, S0});

    // num=0 keeps units visible
    convert(8'd0);
    wait_an(4'b1110, "z0_u_an");
    chk("z0_units", {1'b0, sseg_a}, {1'b0, S0});
    wait_an(4'b1101, "z0_t_an");
    chk("z0_tens", {1'b0, sseg_a}, {1'b0, SBL});

    // Load while busy: line up so digit 3 is scanned during the conversion
    wait_an(4'b1101, "lb_sync1");
    wait_an(4'b1011, "lb_sync2");
    num  = 8'd200;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    num  = 8'd42;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("lb_busy", {7'd0, bus_a.busy}, 8'd1);
    chk("lb_d3_an", {4'd0, an_a}, 8'b0000_0111);
    chk("lb_dash", {1'b0, sseg_a}, {1'b0, SDH});
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_a.done) cnt++;
    end
    chk("lb_done_cnt", cnt[7:0], 8'd1);
    wait_an(4'b1110, "lb_u_an");
    chk("lb_units", {1'b0, sseg_a}, {1'b0, S0});
    wait_an(4'b1101, "lb_t_an");
    chk("lb_tens", {1'b0, sseg_a}, {1'b0, S0});
    wait_an(4'b1011, "lb_h_an");
    chk("lb_hund", {1'b0, sseg_a}, {1'b0, S2});

    // Reset mid-conversion, with load held in the same cycle
    num  = 8'd55;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    rst  = 1'b0;
    load = 1'b1;
    step();
    rst  = 1'b1;
    load = 1'b0;
    chk("mr_busy", {7'd0, bus_a.busy}, 8'd0);
    chk("mr_done", {7'd0, bus_a.done}, 8'd0);
    chk("mr_led",  {7'd0, led_a}, 8'd0);
    chk("mr_an",   {4'd0, an_a}, 8'b0000_1111);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_a.done || bus_a.busy) cnt++;
    end
    chk("mr_quiet", cnt[7:0], 8'd0);
    wait_an(4'b1110, "mr_u_an");
    chk("mr_units", {1'b0, sseg_a}, {1'b0, SBL});
    convert(8'd99);
    wait_an(4'b1110, "n99_u_an");
    chk("n99_units", {1'b0, sseg_a}, {1'b0, S9});
    wait_an(4'b1101, "n99_t_an");
    chk("n99_tens", {1'b0, sseg_a}, {1'b0, S9});
    wait_an(4'b1011, "n99_h_an");
    chk("n99_hund", {1'b0, sseg_a}, {1'b0, SBL});

    // Divider wrap with 128
    convert(8'd128);
    wait_an(4'b0111, "dw_sync");
    wait_an(4'b1110, "dw_u_an");
    chk("dw_units", {1'b0, sseg_a}, {1'b0, S8});
    repeat (3) step();
    chk("dw_hold_an", {4'd0, an_a}, 8'b0000_1110);
    step();
    chk("dw_t_an", {4'd0, an_a}, 8'b0000_1101);
    chk("dw_tens", {1'b0, sseg_a}, {1'b0, S2});
    repeat (4) step();
    chk("dw_h_an", {4'd0, an_a}, 8'b0000_1011);
    chk("dw_hund", {1'b0, sseg_a}, {1'b0, S1});
    repeat (4) step();
    chk("dw_d3_an", {4'd0, an_a}, 8'b0000_0111);
    chk("dw_d3", {1'b0, sseg_a}, {1'b0, SBL});
    repeat (4) step();
    chk("dw_wrap_an", {4'd0, an_a}, 8'b0000_1110);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
